// File: rtl/seq_1011_gen.sv
// seq_1011_gen: serial frame generator that sends a latched pattern MSB first, rpt+1 times.
// Build option: define SEQ_GAP_EN to insert one idle GAP cycle between consecutive frames.
module seq_1011_gen #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned RPT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [RPT_W-1:0] rpt,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

`ifdef SEQ_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [RPT_W-1:0] frames_q, frames_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             x_d, x_valid_d, busy_d, done_d;

  // State, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pat_q    <= '0;
      frames_q <= '0;
      idx_q    <= '0;
      x        <= 1'b0;
      x_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      frames_q <= frames_d;
      idx_q    <= idx_d;
      x        <= x_d;
      x_valid  <= x_valid_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next state and next output values; idx_q is the index of the bit now on x.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    frames_d  = frames_q;
    idx_d     = idx_q;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = SHIFT;
          pat_d     = pattern;
          frames_d  = rpt;
          idx_d     = IDX_MSB;
          x_d       = pattern[PAT_W-1];
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (idx_q != '0) begin
          idx_d     = idx_q - IDX_W'(1);
          x_d       = pat_q[idx_d];
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end else if (frames_q != '0) begin
          frames_d = frames_q - RPT_W'(1);
          busy_d   = 1'b1;
`ifdef SEQ_GAP_EN
          state_d  = GAP;
`else
          idx_d     = IDX_MSB;
          x_d       = pat_q[PAT_W-1];
          x_valid_d = 1'b1;
`endif
        end else begin
          state_d = DONE;
          busy_d  = 1'b1;
          done_d  = 1'b1;
        end
      end
`ifdef SEQ_GAP_EN
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d   = SHIFT;
          idx_d     = IDX_MSB;
          x_d       = pat_q[PAT_W-1];
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_1011_gen.sv
// tb_seq_1011_gen: directed and randomized checks of seq_1011_gen against a stream model.
module tb_seq_1011_gen;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned RPT_W = 4;
`ifdef SEQ_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, start, abort;
  logic [PAT_W-1:0] pattern;
  logic [RPT_W-1:0] rpt;
  logic             x, x_valid, busy, done;

  int n_cmp;
  int n_bad;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  seq_1011_gen #(.PAT_W(PAT_W), .RPT_W(RPT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern(pattern), .rpt(rpt),
    .x(x), .x_valid(x_valid), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {x, x_valid, busy, done} per cycle after the accepting edge.
  task automatic build_expect(input logic [PAT_W-1:0] pat, input int frames);
    exp_q.delete();
    for (int f = 0; f < frames; f++) begin
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({pat[b], 1'b1, 1'b1, 1'b0});
      if (GAP_ON && f != frames - 1) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0011);
    exp_q.push_back(4'b0000);
  endtask

  // kind: 0 clean, 1 abort at cut, 2 rst at cut, 3 re-start + pattern wipe, 4 input noise.
  // Called at a negedge; returns at a negedge with the DUT idle.
  task automatic run_seq(input string name, input logic [PAT_W-1:0] pat, input logic [RPT_W-1:0] r,
                         input int kind, input int cut, input int exp_det);
    logic [3:0] got;
    logic [3:0] win;
    int         det, ndone, last;
    build_expect(pat, int'(r) + 1);
    last    = exp_q.size();
    pattern = pat;
    rpt     = r;
    start   = 1'b1;
    abort   = 1'b0;
    win     = '0;
    det     = 0;
    ndone   = 0;
    for (int i = 1; i <= last; i++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      got   = {x, x_valid, busy, done};
      check($sformatf("%s cyc%0d", name, i), 32'(got), 32'(exp_q[i-1]));
      if (x_valid) begin
        win = {win[2:0], x};
        if (win == 4'b1011) det++;
      end
      ndone += int'(done);
      if ((kind == 1 || kind == 2) && i == cut) begin
        if (kind == 1) abort = 1'b1;
        else rst = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        rst   = 1'b0;
        check($sformatf("%s cut", name), 32'({x, x_valid, busy, done}), 32'h0);
        return;
      end
      if (kind == 3 && i == 2) begin
        start   = 1'b1;
        pattern = '0;
      end
      if (kind == 4 && i < last) begin
        pattern = PAT_W'($urandom);
        rpt     = RPT_W'($urandom);
        start   = 1'($urandom);
        if (i == last - 1) abort = 1'($urandom);
      end
    end
    check($sformatf("%s done_count", name), 32'(ndone), 32'd1);
    if (exp_det >= 0) check($sformatf("%s detects", name), 32'(det), 32'(exp_det));
  endtask

  initial begin
    int len, kind, cut;
    logic [PAT_W-1:0] p;
    logic [RPT_W-1:0] r;
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    pattern = '0;
    rpt     = '0;
    repeat (2) @(negedge clk);
    check("reset", 32'({x, x_valid, busy, done}), 32'h0);
    start = 1'b1;
    @(negedge clk);
    check("rst_over_start", 32'({x, x_valid, busy, done}), 32'h0);
    rst = 1'b0;

    run_seq("single", 4'b1011, 4'd0, 0, 0, 1);
    run_seq("rpt2", 4'b1011, 4'd2, 0, 0, 3);
    run_seq("restart_wipe", 4'b1011, 4'd1, 3, 0, 2);
    run_seq("abort3", 4'b1011, 4'd2, 1, 3, -1);
    run_seq("after_abort", 4'b1011, 4'd0, 0, 0, 1);
    run_seq("rst3", 4'b1011, 4'd2, 2, 3, -1);
    run_seq("after_rst", 4'b0110, 4'd1, 0, 0, -1);

    start = 1'b1;
    abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check($sformatf("start_abort cyc%0d", i + 1), 32'({x, x_valid, busy, done}), 32'h0);
    end

    run_seq("rpt_max", 4'b1011, '1, 0, 0, 1 << RPT_W);

    for (int t = 0; t < 40; t++) begin
      p    = PAT_W'($urandom);
      r    = RPT_W'($urandom_range(0, 5));
      kind = int'($urandom_range(0, 4));
      len  = (int'(r) + 1) * PAT_W + (GAP_ON ? int'(r) : 0) + 2;
      cut  = int'($urandom_range(1, len - 2));
      run_seq($sformatf("rnd%0d", t), p, r, kind, cut, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
